// File: rtl/cpu_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with round-robin replacement.
// Optional hit/miss counters are compiled in when CPU_CACHE_STATS_EN is defined.
module cpu_assoc_cache #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              mem_req_read,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data
`ifdef CPU_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  // state     | meaning
  // IDLE      | lookup; hits complete in the same cycle, misses pick a victim
  // WRITEBACK | victim line is dirty, write it to memory
  // FILL      | fetch the requested line into the victim way

  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS  = LINE_W / WORD_W;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL
  } state_t;

  state_t state, state_next;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  victim_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              access;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              miss_start;
  logic              wb_done;
  logic              fill_done;
  logic              write_hit;
  logic [WAY_W-1:0]  rr_next;
  logic              unused_addr_bits;

  assign req_idx          = req_addr[OFF_W +: IDX_W];
  assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
  assign access           = req_read | req_write;
  assign unused_addr_bits = ^req_addr[BYTE_W-1:0];

  generate
    if (WORDS > 1) begin : g_wsel
      assign word_sel = req_addr[OFF_W-1:BYTE_W];
    end else begin : g_wsel_one
      assign word_sel = '0;
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; a full set falls back to the RR pointer.
  always_comb begin
    victim = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = WAY_W'(w);
    end
  end

  assign rr_next = (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    rsp_valid     = 1'b0;
    mem_req_read  = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
    miss_start    = 1'b0;
    wb_done       = 1'b0;
    fill_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            rsp_valid = 1'b1;
          end else begin
            miss_start = 1'b1;
            if (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
              state_next = S_WRITEBACK;
            else
              state_next = S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[req_idx][victim_q], req_idx, {OFF_W{1'b0}}};
        if (mem_rsp_valid) begin
          wb_done    = 1'b1;
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        mem_req_read = 1'b1;
        if (mem_rsp_valid) begin
          fill_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (reset) begin
      state_next    = S_IDLE;
      rsp_valid     = 1'b0;
      mem_req_read  = 1'b0;
      mem_req_write = 1'b0;
      miss_start    = 1'b0;
      wb_done       = 1'b0;
      fill_done     = 1'b0;
    end
  end

  assign write_hit     = rsp_valid & req_write;
  assign rsp_rdata     = data_q[req_idx][hit_way][word_sel*WORD_W +: WORD_W];
  assign mem_req_wdata = data_q[req_idx][victim_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (miss_start) victim_q <= victim;
      if (write_hit) dirty_q[req_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[req_idx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
        rr_q[req_idx]              <= rr_next;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (fill_done) begin
      data_q[req_idx][victim_q] <= mem_rsp_data;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
    if (write_hit) data_q[req_idx][hit_way][word_sel*WORD_W +: WORD_W] <= req_wdata;
  end

`ifdef CPU_CACHE_STATS_EN
  logic filled_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      filled_q   <= 1'b0;
    end else begin
      if (miss_start) miss_count <= miss_count + 32'd1;
      if (fill_done) filled_q <= 1'b1;
      if (rsp_valid) begin
        if (!filled_q) hit_count <= hit_count + 32'd1;
        filled_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_assoc_cache.sv
// Scoreboard bench for cpu_assoc_cache: a bench-side memory and word-level reference
// model supply expected read data, writeback lines and refill addresses.
module tb_cpu_assoc_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_read, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         mem_req_read, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
`ifdef CPU_CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  cpu_assoc_cache dut (
    .clock(clock), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef CPU_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NO_WB = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]  exp_q [$];
  logic [127:0] mem_line [logic [31:0]];
  logic [31:0]  ref_word [logic [31:0]];
  logic [127:0] last_wb;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] get_line(input logic [31:0] la);
    logic [127:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = {la[15:0] + 16'(i), 16'hC0DE};
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0]  wa;
    logic [127:0] l;
    wa = a & ~32'h3;
    if (ref_word.exists(wa)) return ref_word[wa];
    l = get_line(a & ~32'hF);
    return l[wa[3:2]*32 +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = ref_rd(la + 32'(4 * i));
    return l;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = '0;
    mem_rsp_valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_rd", mem_req_read, 0);
      chk("rst_mem_wr", mem_req_write, 0);
    end
    reset = 1'b0; req_read = 1'b0;
    ref_word.delete();
    exp_q.delete();
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_fills, input int exp_wbs, input logic [31:0] exp_wb_addr);
    int cyc, fills, wbs, ack_cyc, wait_cnt;
    bit done, ack_was;
    logic [31:0] la;
    @(posedge clock); #1;
    req_read = !wr; req_write = wr; req_addr = addr; req_wdata = wdata;
    if (!wr) exp_q.push_back(ref_rd(addr));
    cyc = 0; fills = 0; wbs = 0; ack_cyc = -10; wait_cnt = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clock);
      ack_was = mem_rsp_valid;
      mem_rsp_valid = 1'b0;
      if (mem_req_read && mem_req_write) chk("mem_exclusive", 1, 0);
      if (rsp_valid) begin
        if (!wr) begin
          if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
          else chk("rdata", rsp_rdata, exp_q.pop_front());
        end else begin
          ref_word[addr & ~32'h3] = wdata;
        end
        if (fills == 0) chk("hit_latency", cyc, 0);
        else chk("fill_latency", cyc - ack_cyc, 1);
        done = 1;
      end else if (!ack_was && (mem_req_read || mem_req_write)) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt = 0;
          la = mem_req_addr;
          if (mem_req_write) begin
            wbs++;
            if (exp_wb_addr != NO_WB) chk("wb_addr", la, exp_wb_addr);
            chk("wb_data", mem_req_wdata, ref_line(la));
            mem_line[la] = mem_req_wdata;
            last_wb = mem_req_wdata;
          end else begin
            fills++;
            chk("fill_addr", la, addr & ~32'hF);
            mem_rsp_data = get_line(la);
            ack_cyc = cyc;
          end
          mem_rsp_valid = 1'b1;
        end
      end
      cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    if (exp_fills >= 0) chk("fill_count", fills, exp_fills);
    if (exp_wbs >= 0) chk("wb_count", wbs, exp_wbs);
    @(posedge clock); #1;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    int seen;
    logic [31:0] a;
    mem_rsp_data = '0;
    mem_line[32'h0] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    last_wb = '0;

    // Cold fill of line 0, then same-cycle hits on the remaining words.
    do_reset();
    access(0, 32'h0, 0, 1, 0, NO_WB);
    access(0, 32'h4, 0, 0, 0, NO_WB);
    access(0, 32'h8, 0, 0, 0, NO_WB);
    access(0, 32'hC, 0, 0, 0, NO_WB);
`ifdef CPU_CACHE_STATS_EN
    chk("miss_count", miss_count, 1);
    chk("hit_count", hit_count, 3);
`endif

    // Second way of set 0, dirty word, then a dirty eviction.
    access(0, 32'h100, 0, 1, 0, NO_WB);
    access(0, 32'h0, 0, 0, 0, NO_WB);
    access(1, 32'h4, 32'h12345678, 0, 0, NO_WB);
    access(0, 32'h200, 0, 1, 1, 32'h0);
    chk("wb_line_literal", last_wb, 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA);
    access(0, 32'h0, 0, 1, 0, NO_WB);
    access(0, 32'h4, 0, 0, 0, NO_WB);

    // Clean evictions only refill.
    do_reset();
    access(0, 32'h0, 0, 1, 0, NO_WB);
    access(0, 32'h100, 0, 1, 0, NO_WB);
    access(0, 32'h200, 0, 1, 0, NO_WB);
    access(0, 32'h104, 0, 0, 0, NO_WB);

    // Reset while a refill is outstanding.
    do_reset();
    @(posedge clock); #1;
    req_read = 1'b1; req_addr = 32'h0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clock);
      if (mem_req_read) seen = 1;
    end
    chk("fill_started", seen, 1);
    reset = 1'b1;
    #1 chk("rst_fill_rd", mem_req_read, 0);
    @(negedge clock);
    chk("rst_fill_rd_hold", mem_req_read, 0);
    reset = 1'b0; req_read = 1'b0;
    ref_word.delete();
    @(negedge clock);
    chk("post_rst_idle_rd", mem_req_read, 0);
    chk("post_rst_idle_wr", mem_req_write, 0);
    access(0, 32'h0, 0, 1, 0, NO_WB);

    // Mixed random traffic over a few tags in two sets.
    for (int i = 0; i < 40; i++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 3'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, -1, -1, NO_WB);
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
